// File: rtl/div_arb_pkg.sv
// div_arbiter shared types: FSM encodings, round-robin pick, DBZ quotient.
// Optional remainder output is enabled by DIV_ARB_REMAINDER_EN.
package div_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [255:0] DBZ_Q = '1;

  function automatic logic [31:0] rr_grant(
    input logic [31:0] mask,
    input int          ptr,
    input int          n
  );
    int idx;
    rr_grant = '0;
    for (int k = 0; k < 32; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && rr_grant == '0 && mask[idx])
        rr_grant[idx] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/div_arbiter_core.sv
// Bit-serial restoring divider, one quotient bit per clock.
// Used by div_arbiter; DIV_ARB_REMAINDER_EN only affects the top.
module div_serial_core
  import div_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rsh;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             ge;

  // Trial shift and compare for the current step
  always_comb begin
    rsh  = {rem[WIDTH-1:0], areg[WIDTH-1]};
    ge   = rsh >= {1'b0, breg};
    done = run && (cnt == CW'(WIDTH - 1));
  end

  // Load on start, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      areg <= '0;
      breg <= '0;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      areg <= a;
      breg <= b;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      areg <= {areg[WIDTH-2:0], ge};
      rem  <= ge ? rsh - {1'b0, breg} : rsh;
      if (done) begin
        cnt <= '0;
        run <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign q = areg;
  assign r = rem[WIDTH-1:0];

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one serial divider among NREQ clients.
// Define DIV_ARB_REMAINDER_EN to add the rsp_r remainder output.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic                  rsp_dbz,
`ifdef DIV_ARB_REMAINDER_EN
  output logic [WIDTH-1:0]      rsp_r,
`endif
  output logic                  busy
);

  logic [1:0]       state;
  logic [IDW-1:0]   rr;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   id_q;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic             dbz_q;
  logic             hs;
  logic             bzero;
  logic             core_done;

  // Round-robin pick and operand mux for the winner
  always_comb begin
    grant = NREQ'(rr_grant(32'(req_valid), int'(rr), NREQ));
    gidx  = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) gidx = IDW'(i);
    a_sel     = req_a[int'(gidx)*WIDTH +: WIDTH];
    b_sel     = req_b[int'(gidx)*WIDTH +: WIDTH];
    bzero     = (b_sel == '0);
    req_ready = (state == IDLE && !rst) ? grant : '0;
    hs        = |req_ready;
  end

  div_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (hs && !bzero),
    .a     (a_sel),
    .b     (b_sel),
    .done  (core_done),
    .q     (core_q),
    .r     (core_r)
  );

`ifdef DIV_ARB_REMAINDER_EN
  logic [WIDTH-1:0] a_q;

  // Dividend kept for the divide-by-zero remainder
  always_ff @(posedge clk) begin
    if (rst)
      a_q <= '0;
    else if (hs)
      a_q <= a_sel;
  end

  assign rsp_r = rsp_valid ? (dbz_q ? a_q : core_r) : '0;
`else
  logic unused_rem;
  assign unused_rem = &{1'b0, core_r};
`endif

  // Control FSM: grant, divide, hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr    <= '0;
      id_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          id_q  <= gidx;
          dbz_q <= bzero;
          rr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state <= bzero ? DONE : RUN;
        end
        RUN: if (core_done) state <= DONE;
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign rsp_dbz   = rsp_valid && dbz_q;
  assign rsp_q     = rsp_valid ? (dbz_q ? DBZ_Q[WIDTH-1:0] : core_q) : '0;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter.
// Remainder checks are active when DIV_ARB_REMAINDER_EN is defined.
module tb_div_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q;
  logic                  rsp_dbz;
  logic                  busy;
`ifdef DIV_ARB_REMAINDER_EN
  logic [WIDTH-1:0]      rsp_r;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_dbz   (rsp_dbz),
`ifdef DIV_ARB_REMAINDER_EN
    .rsp_r     (rsp_r),
`endif
    .busy      (busy)
  );

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_id, rsp_dbz} !== '0 || rsp_q !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b ready=%b id=%0d dbz=%b q=%h, expected all zero",
               rsp_valid, busy, req_ready, rsp_id, rsp_dbz, rsp_q);
    end
`ifdef DIV_ARB_REMAINDER_EN
    checks++;
    if (rsp_r !== '0) begin
      errors++;
      $display("FAIL reset_r: got %h expected 0", rsp_r);
    end
`endif
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_divide;
    int          vid[4] = '{0, 2, 2, 2};
    logic [31:0] va[4]  = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    logic [31:0] vb[4]  = '{32'd7, 32'd1, 32'd9, 32'h8000_0000};
    logic [31:0] vq[4]  = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] vr[4]  = '{32'd2, 32'd0, 32'd5, 32'd0};
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a[vid[i]*WIDTH +: WIDTH] = va[i];
      req_b[vid[i]*WIDTH +: WIDTH] = vb[i];
      req_valid = '0;
      req_valid[vid[i]] = 1'b1;
      #1;
      checks++;
      if (req_ready !== req_valid) begin
        errors++;
        $display("FAIL div%0d_ready: got %b expected %b", i, req_ready, req_valid);
      end
      @(posedge clk);
      #1 req_valid = '0;
      n = 0;
      while (n < 100) begin
        @(negedge clk);
        n++;
        if (rsp_valid) break;
      end
      checks++;
      if (n !== WIDTH + 1 || !rsp_valid) begin
        errors++;
        $display("FAIL div%0d_latency: got %0d cycles (valid=%b) expected %0d", i, n, rsp_valid, WIDTH + 1);
      end
      checks++;
      if (rsp_q !== vq[i] || rsp_id !== IDW'(vid[i]) || rsp_dbz !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_result: q=%h id=%0d dbz=%b expected q=%h id=%0d dbz=0",
                 i, rsp_q, rsp_id, rsp_dbz, vq[i], vid[i]);
      end
`ifdef DIV_ARB_REMAINDER_EN
      checks++;
      if (rsp_r !== vr[i]) begin
        errors++;
        $display("FAIL div%0d_rem: got %h expected %h", i, rsp_r, vr[i]);
      end
`else
      if (vr[i] === 32'hDEAD_BEEF) $display("unexpected remainder vector");
`endif
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_drop: rsp_valid=%b expected 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_dbz;
    @(negedge clk);
    req_a[1*WIDTH +: WIDTH] = 32'd123;
    req_b[1*WIDTH +: WIDTH] = 32'd0;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL dbz_ready: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_q !== 32'hFFFF_FFFF || rsp_dbz !== 1'b1 || rsp_id !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: valid=%b q=%h dbz=%b id=%0d busy=%b expected 1 ffffffff 1 1 1",
               rsp_valid, rsp_q, rsp_dbz, rsp_id, busy);
    end
`ifdef DIV_ARB_REMAINDER_EN
    checks++;
    if (rsp_r !== 32'd123) begin
      errors++;
      $display("FAIL dbz_rem: got %0d expected 123", rsp_r);
    end
`endif
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_idle: valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    int g  = 0;
    int rc = 0;
    int cyc = 0;
    int idx;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 32'(100 + i);
      req_b[i*WIDTH +: WIDTH] = 32'd1;
    end
    req_valid = 4'b1111;
    while (rc < 5 && cyc < 400) begin
      #1;
      if (req_ready !== 4'b0000) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        checks++;
        if (!$onehot(req_ready) || idx !== (g % NREQ) || g >= 5) begin
          errors++;
          $display("FAIL rr_grant%0d: ready=%b expected one-hot bit %0d", g, req_ready, g % NREQ);
        end
        g++;
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== IDW'(rc % NREQ) || rsp_q !== 32'(100 + rc % NREQ)) begin
          errors++;
          $display("FAIL rr_rsp%0d: id=%0d q=%0d expected id=%0d q=%0d",
                   rc, rsp_id, rsp_q, rc % NREQ, 100 + rc % NREQ);
        end
        rc++;
      end
      if (rc == 5) break;
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    checks++;
    if (rc !== 5 || g !== 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d responses=%0d expected 5 5", g, rc);
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int bad = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_a[3*WIDTH +: WIDTH] = 32'd1000;
    req_b[3*WIDTH +: WIDTH] = 32'd10;
    req_a[0*WIDTH +: WIDTH] = 32'd77;
    req_b[0*WIDTH +: WIDTH] = 32'd7;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL bp_timeout: rsp_valid=%b expected 1", rsp_valid);
    end
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_q !== 32'd100 || rsp_id !== 2'd3 || req_ready !== 4'b0000)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, last valid=%b q=%0d id=%0d ready=%b expected 1 100 3 0000",
               bad, rsp_valid, rsp_q, rsp_id, req_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 0001", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_q !== 32'd11 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL bp_next: valid=%b q=%0d id=%0d expected 1 11 0", rsp_valid, rsp_q, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int seen = 0;
    int n = 0;
    @(negedge clk);
    req_a[1*WIDTH +: WIDTH] = 32'd1000;
    req_b[1*WIDTH +: WIDTH] = 32'd3;
    req_a[2*WIDTH +: WIDTH] = 32'd50;
    req_b[2*WIDTH +: WIDTH] = 32'd5;
    req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_id, rsp_dbz} !== '0 || rsp_q !== '0) begin
      errors++;
      $display("FAIL abort_outputs: valid=%b busy=%b ready=%b id=%0d dbz=%b q=%h expected all zero",
               rsp_valid, busy, req_ready, rsp_id, rsp_dbz, rsp_q);
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_norsp: rsp_valid seen %0d cycles expected 0", seen);
    end
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL abort_rr: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_q !== 32'd333 || rsp_id !== 2'd1 || n !== WIDTH + 1) begin
      errors++;
      $display("FAIL abort_fresh: valid=%b q=%0d id=%0d cycles=%0d expected 1 333 1 %0d",
               rsp_valid, rsp_q, rsp_id, n, WIDTH + 1);
    end
`ifdef DIV_ARB_REMAINDER_EN
    checks++;
    if (rsp_r !== 32'd1) begin
      errors++;
      $display("FAIL abort_rem: got %0d expected 1", rsp_r);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_dbz();
    test_round_robin();
    test_backpressure();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
